// File: rtl/crossing_pkg.sv
// ---------------------------------------------------------------------------
// crossing_pkg
// Shared definitions for the crossing scheduler:
//   - state_e      : phase states of the two-way crossing controller
//   - LIGHT_*      : 2-bit vehicle signal encodings (11 is never driven)
//   - DEF_*        : default timing constants in clock cycles
//   - maxOf        : small helper for sizing counters from parameters
// ---------------------------------------------------------------------------
package crossing_pkg;

  // The controller walks NS_GRN..CLR_B in this order; the WALK/CLR states
  // are skipped when nobody is waiting to cross.
  typedef enum logic [3:0] {
    NS_GRN,
    NS_YEL,
    RED_A,
    WALK_A,
    CLR_A,
    EW_GRN,
    EW_YEL,
    RED_B,
    WALK_B,
    CLR_B
  } state_e;

  localparam logic [1:0] LIGHT_RED    = 2'b00;
  localparam logic [1:0] LIGHT_GREEN  = 2'b01;
  localparam logic [1:0] LIGHT_YELLOW = 2'b10;

  localparam int DEF_MIN_GREEN = 8;
  localparam int DEF_MAX_GREEN = 20;
  localparam int DEF_YELLOW_T  = 3;
  localparam int DEF_CLEAR_T   = 2;
  localparam int DEF_WALK_T    = 6;

  function automatic int maxOf(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/crossing_scheduler_if.sv
// ---------------------------------------------------------------------------
// crossing_scheduler_if
// Bundles the crossing's sensor inputs and signal outputs.
//   ped_req_ns / ped_req_ew     : pedestrian buttons (any-width pulses)
//   car_sense_ns / car_sense_ew : vehicle waiting on each approach (level)
//   ns_light / ew_light         : vehicle signals (crossing_pkg LIGHT_*)
//   walk_ns / walk_ew           : walk indications per crossing
//   ped_pending                 : latched unserved requests {ew,ns}
// Modports:
//   master : environment side, drives buttons/sensors, observes signals
//   slave  : controller side
// ---------------------------------------------------------------------------
interface crossing_scheduler_if;

  logic       ped_req_ns;
  logic       ped_req_ew;
  logic       car_sense_ns;
  logic       car_sense_ew;
  logic [1:0] ns_light;
  logic [1:0] ew_light;
  logic       walk_ns;
  logic       walk_ew;
  logic [1:0] ped_pending;

  modport master (
    output ped_req_ns, ped_req_ew, car_sense_ns, car_sense_ew,
    input  ns_light, ew_light, walk_ns, walk_ew, ped_pending
  );

  modport slave (
    input  ped_req_ns, ped_req_ew, car_sense_ns, car_sense_ew,
    output ns_light, ew_light, walk_ns, walk_ew, ped_pending
  );

endinterface

// File: rtl/phase_timer.sv
// ---------------------------------------------------------------------------
// phase_timer
// Down-counter timing the fixed-length phases (yellow, red, walk, clear).
// Loaded with (length-1) on phase entry; o_expire is high in the last cycle
// of the phase, so the owner leaves the phase at that edge.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   i_load       : load strobe (phase entry)
//   i_loadValue  : value to load, length-1 of the phase being entered
//   o_expire     : counter has reached zero
// ---------------------------------------------------------------------------
module phase_timer #(
  parameter int               WIDTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_loadValue,
  output logic             o_expire
);

  logic [WIDTH-1:0] r_count;

  // Reset leaves the timer already running for the reset phase; afterwards
  // it counts down to zero and holds there until the next load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= RESET_VALUE;
    end else if (i_load) begin
      r_count <= i_loadValue;
    end else if (r_count != '0) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign o_expire = (r_count == '0);

endmodule

// File: rtl/crossing_scheduler.sv
// ---------------------------------------------------------------------------
// crossing_scheduler
// Two-way traffic crossing controller with pedestrian walk phases.
// Sequence: NS green -> NS yellow -> all red -> (walk -> clear) -> EW green
//           -> EW yellow -> all red -> (walk -> clear) -> NS green.
// Green length adapts between MIN_GREEN and MAX_GREEN depending on waiting
// pedestrians and the opposing car sensor; the other phases are fixed.
// Ports:
//   clk    : clock, all state changes on rising edge
//   rst    : asynchronous active-high reset (forces RED_B, nothing pending)
//   io_bus : crossing_scheduler_if.slave (buttons, sensors, signals)
// ---------------------------------------------------------------------------
module crossing_scheduler
  import crossing_pkg::*;
#(
  parameter int MIN_GREEN = DEF_MIN_GREEN,
  parameter int MAX_GREEN = DEF_MAX_GREEN,
  parameter int YELLOW_T  = DEF_YELLOW_T,
  parameter int CLEAR_T   = DEF_CLEAR_T,
  parameter int WALK_T    = DEF_WALK_T
) (
  input  logic                  clk,
  input  logic                  rst,
  crossing_scheduler_if.slave   io_bus
);

  localparam int LONGEST = maxOf(maxOf(YELLOW_T, CLEAR_T), WALK_T);
  localparam int TIMER_W = maxOf($clog2(LONGEST), 1);
  localparam int GREEN_W = maxOf($clog2(MAX_GREEN), 1);

  state_e               r_state;
  state_e               w_nextState;
  logic [GREEN_W-1:0]   r_greenCount;
  logic [1:0]           r_pending;
  logic [1:0]           r_walkMask;

  logic [1:0]           w_buttons;
  logic                 w_expire;
  logic                 w_greenMin;
  logic                 w_greenMax;
  logic                 w_nsGreenExit;
  logic                 w_ewGreenExit;
  logic                 w_serve;
  logic                 w_load;
  logic                 w_enterWalk;
  logic [TIMER_W-1:0]   w_loadValue;

  assign w_buttons = {io_bus.ped_req_ew, io_bus.ped_req_ns};

  // A green may end once it has run MIN_GREEN cycles and someone is waiting
  // (a pedestrian or a car on the cross road); it must end at MAX_GREEN.
  assign w_greenMin    = (r_greenCount >= GREEN_W'(MIN_GREEN - 1));
  assign w_greenMax    = (r_greenCount == GREEN_W'(MAX_GREEN - 1));
  assign w_nsGreenExit = (w_greenMin && ((r_pending != 2'b00) || io_bus.car_sense_ew)) || w_greenMax;
  assign w_ewGreenExit = (w_greenMin && ((r_pending != 2'b00) || io_bus.car_sense_ns)) || w_greenMax;

  // A button pressed in the very cycle the all-red phase ends still earns a
  // walk phase, so the live buttons are folded in alongside the latch.
  assign w_serve = ((r_pending | w_buttons) != 2'b00);

  // Next-state selection. Every phase exit moves to a different state, so a
  // state change is also the timer's load strobe.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      NS_GRN:  if (w_nsGreenExit) w_nextState = NS_YEL;
      NS_YEL:  if (w_expire)      w_nextState = RED_A;
      RED_A:   if (w_expire)      w_nextState = w_serve ? WALK_A : EW_GRN;
      WALK_A:  if (w_expire)      w_nextState = CLR_A;
      CLR_A:   if (w_expire)      w_nextState = EW_GRN;
      EW_GRN:  if (w_ewGreenExit) w_nextState = EW_YEL;
      EW_YEL:  if (w_expire)      w_nextState = RED_B;
      RED_B:   if (w_expire)      w_nextState = w_serve ? WALK_B : NS_GRN;
      WALK_B:  if (w_expire)      w_nextState = CLR_B;
      CLR_B:   if (w_expire)      w_nextState = NS_GRN;
      default:                    w_nextState = RED_B;
    endcase
  end

  // Timer load: on entry to a fixed-length phase load length-1. Greens are
  // timed by the up-counter, so the loaded value there does not matter.
  always_comb begin
    w_load      = (w_nextState != r_state);
    w_enterWalk = w_load && ((w_nextState == WALK_A) || (w_nextState == WALK_B));
    w_loadValue = '0;
    case (w_nextState)
      NS_YEL, EW_YEL:             w_loadValue = TIMER_W'(YELLOW_T - 1);
      RED_A, RED_B, CLR_A, CLR_B: w_loadValue = TIMER_W'(CLEAR_T - 1);
      WALK_A, WALK_B:             w_loadValue = TIMER_W'(WALK_T - 1);
      default:                    w_loadValue = '0;
    endcase
  end

  phase_timer #(
    .WIDTH       (TIMER_W),
    .RESET_VALUE (TIMER_W'(CLEAR_T - 1))
  ) u_phaseTimer (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_load),
    .i_loadValue (w_loadValue),
    .o_expire    (w_expire)
  );

  // Main FSM register plus the green up-counter and the pedestrian latches.
  // On walk entry the mask captures everyone waiting and the latch clears;
  // during a walk only the crossing not being served can queue a request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= RED_B;
      r_greenCount <= '0;
      r_pending    <= 2'b00;
      r_walkMask   <= 2'b00;
    end else begin
      r_state <= w_nextState;

      if (w_load) begin
        r_greenCount <= '0;
      end else if ((r_state == NS_GRN) || (r_state == EW_GRN)) begin
        r_greenCount <= r_greenCount + GREEN_W'(1);
      end

      if (w_enterWalk) begin
        r_walkMask <= r_pending | w_buttons;
        r_pending  <= 2'b00;
      end else if ((r_state == WALK_A) || (r_state == WALK_B)) begin
        r_pending <= r_pending | (w_buttons & ~r_walkMask);
      end else begin
        r_pending <= r_pending | w_buttons;
      end
    end
  end

  // Outputs depend only on registers, so a walk can never overlap a
  // non-red vehicle light and reset takes effect without a clock.
  always_comb begin
    io_bus.ns_light = LIGHT_RED;
    io_bus.ew_light = LIGHT_RED;
    io_bus.walk_ns  = 1'b0;
    io_bus.walk_ew  = 1'b0;
    case (r_state)
      NS_GRN:         io_bus.ns_light = LIGHT_GREEN;
      NS_YEL:         io_bus.ns_light = LIGHT_YELLOW;
      EW_GRN:         io_bus.ew_light = LIGHT_GREEN;
      EW_YEL:         io_bus.ew_light = LIGHT_YELLOW;
      WALK_A, WALK_B: begin
        io_bus.walk_ns = r_walkMask[0];
        io_bus.walk_ew = r_walkMask[1];
      end
      default: ;
    endcase
  end

  assign io_bus.ped_pending = r_pending;

endmodule

// File: tb/tb_crossing_scheduler.sv
// ---------------------------------------------------------------------------
// tb_crossing_scheduler
// Directed segment tables for the documented scenarios, a hand-written
// asynchronous reset sequence, and a randomized run against a phase/age
// reference model of the crossing.
// ---------------------------------------------------------------------------
module tb_crossing_scheduler;

  localparam int T_MIN   = 8;
  localparam int T_MAX   = 20;
  localparam int T_YEL   = 3;
  localparam int T_CLR   = 2;
  localparam int T_WALK  = 6;

  localparam logic [1:0] R = 2'd0;
  localparam logic [1:0] G = 2'd1;
  localparam logic [1:0] Y = 2'd2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  crossing_scheduler_if bus ();

  crossing_scheduler #(
    .MIN_GREEN (T_MIN),
    .MAX_GREEN (T_MAX),
    .YELLOW_T  (T_YEL),
    .CLEAR_T   (T_CLR),
    .WALK_T    (T_WALK)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  // Each record holds inputs for 'len' cycles and the outputs required in
  // every one of those cycles; 'rf' requests a fresh reset first.
  typedef struct {
    bit         rf;
    int         len;
    logic       pn, pe, cn, ce;
    logic [1:0] ns, ew;
    logic       wn, we;
    logic [1:0] pend;
  } seg_t;

  seg_t table_q[$];

  task automatic addSeg(input bit rf, input int len, input logic pn, input logic pe,
                        input logic cn, input logic ce, input logic [1:0] ns,
                        input logic [1:0] ew, input logic wn, input logic we,
                        input logic [1:0] pend);
    seg_t s;
    s.rf = rf; s.len = len; s.pn = pn; s.pe = pe; s.cn = cn; s.ce = ce;
    s.ns = ns; s.ew = ew; s.wn = wn; s.we = we; s.pend = pend;
    table_q.push_back(s);
  endtask

  // Reference model: position in the 10-phase ring (0 NS green .. 9 clear B)
  // and how many cycles have already been spent in that phase.
  int         mPhase = 7;
  int         mAge   = 0;
  logic [1:0] mPend  = 2'b00;
  logic [1:0] mMask  = 2'b00;
  logic [1:0] tbBtn;

  assign tbBtn = {bus.ped_req_ew, bus.ped_req_ns};

  function automatic int phaseLen(input int p);
    case (p)
      1, 6:       return T_YEL;
      2, 4, 7, 9: return T_CLR;
      3, 8:       return T_WALK;
      default:    return 0;
    endcase
  endfunction

  function automatic bit leaves(input int p, input int a, input logic [1:0] pend,
                                input logic cn, input logic ce);
    logic opp;
    if (p == 0 || p == 5) begin
      opp = (p == 0) ? ce : cn;
      return ((a + 1 >= T_MIN) && ((pend != 2'b00) || opp)) || (a + 1 >= T_MAX);
    end
    return (a + 1 >= phaseLen(p));
  endfunction

  function automatic int nextOf(input int p, input bit serve);
    if ((p == 2 || p == 7) && !serve) return (p + 3) % 10;
    return (p + 1) % 10;
  endfunction

  function automatic logic [1:0] lightOf(input int p, input int greenPhase);
    if (p == greenPhase)     return G;
    if (p == greenPhase + 1) return Y;
    return R;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mPhase <= 7;
      mAge   <= 0;
      mPend  <= 2'b00;
      mMask  <= 2'b00;
    end else if (leaves(mPhase, mAge, mPend, bus.car_sense_ns, bus.car_sense_ew)) begin
      mPhase <= nextOf(mPhase, (mPend | tbBtn) != 2'b00);
      mAge   <= 0;
      if ((mPhase == 2 || mPhase == 7) && ((mPend | tbBtn) != 2'b00)) begin
        mMask <= mPend | tbBtn;
        mPend <= 2'b00;
      end else if (mPhase == 3 || mPhase == 8) begin
        mPend <= mPend | (tbBtn & ~mMask);
      end else begin
        mPend <= mPend | tbBtn;
      end
    end else begin
      mAge <= mAge + 1;
      if (mPhase == 3 || mPhase == 8) mPend <= mPend | (tbBtn & ~mMask);
      else                            mPend <= mPend | tbBtn;
    end
  end

  task automatic applyStimulus(input logic pn, input logic pe, input logic cn, input logic ce);
    bus.ped_req_ns   = pn;
    bus.ped_req_ew   = pe;
    bus.car_sense_ns = cn;
    bus.car_sense_ew = ce;
  endtask

  task automatic checkOutput(input string name, input logic [1:0] ns, input logic [1:0] ew,
                             input logic wn, input logic we, input logic [1:0] pend);
    total++;
    if (bus.ns_light !== ns || bus.ew_light !== ew || bus.walk_ns !== wn ||
        bus.walk_ew !== we || bus.ped_pending !== pend) begin
      bad++;
      $display("[TB] FAIL %s: got ns=%0d ew=%0d walk_ns=%b walk_ew=%b pend=%b, want ns=%0d ew=%0d walk_ns=%b walk_ew=%b pend=%b",
               name, bus.ns_light, bus.ew_light, bus.walk_ns, bus.walk_ew, bus.ped_pending,
               ns, ew, wn, we, pend);
    end
  endtask

  // Holds reset for three clocks with quiet inputs; returns at a falling
  // edge with reset just released.
  task automatic doReset();
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic runTable(input int lo, input int hi, input bit skipFirstReset);
    for (int i = lo; i < hi; i++) begin
      if (table_q[i].rf && !(skipFirstReset && i == lo)) doReset();
      for (int k = 0; k < table_q[i].len; k++) begin
        checkOutput($sformatf("seg%0d.%0d", i, k), table_q[i].ns, table_q[i].ew,
                    table_q[i].wn, table_q[i].we, table_q[i].pend);
        applyStimulus(table_q[i].pn, table_q[i].pe, table_q[i].cn, table_q[i].ce);
        @(posedge clk);
        @(negedge clk);
      end
    end
  endtask

  int s032, s033, s034, s035, s036, s037, sEnd;

  initial begin
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    // Idle crossing: two red cycles after reset, then full-length greens.
    s032 = table_q.size();
    addSeg(1,  2, 0,0,0,0, R,R, 0,0, 2'b00);
    addSeg(0, 20, 0,0,0,0, G,R, 0,0, 2'b00);
    addSeg(0,  3, 0,0,0,0, Y,R, 0,0, 2'b00);
    addSeg(0,  2, 0,0,0,0, R,R, 0,0, 2'b00);
    addSeg(0, 20, 0,0,0,0, R,G, 0,0, 2'b00);
    addSeg(0,  1, 0,0,0,0, R,Y, 0,0, 2'b00);

    // EW car always waiting: NS green cut to minimum, EW green runs full.
    s033 = table_q.size();
    addSeg(1,  2, 0,0,0,1, R,R, 0,0, 2'b00);
    addSeg(0,  8, 0,0,0,1, G,R, 0,0, 2'b00);
    addSeg(0,  3, 0,0,0,1, Y,R, 0,0, 2'b00);
    addSeg(0,  2, 0,0,0,1, R,R, 0,0, 2'b00);
    addSeg(0, 20, 0,0,0,1, R,G, 0,0, 2'b00);
    addSeg(0,  3, 0,0,0,1, R,Y, 0,0, 2'b00);
    addSeg(0,  2, 0,0,0,1, R,R, 0,0, 2'b00);
    addSeg(0,  8, 0,0,0,1, G,R, 0,0, 2'b00);
    addSeg(0,  1, 0,0,0,1, Y,R, 0,0, 2'b00);

    // One NS button pulse in green cycle 3.
    s034 = table_q.size();
    addSeg(1,  2, 0,0,0,0, R,R, 0,0, 2'b00);
    addSeg(0,  3, 0,0,0,0, G,R, 0,0, 2'b00);
    addSeg(0,  1, 1,0,0,0, G,R, 0,0, 2'b00);
    addSeg(0,  4, 0,0,0,0, G,R, 0,0, 2'b01);
    addSeg(0,  3, 0,0,0,0, Y,R, 0,0, 2'b01);
    addSeg(0,  2, 0,0,0,0, R,R, 0,0, 2'b01);
    addSeg(0,  6, 0,0,0,0, R,R, 1,0, 2'b00);
    addSeg(0,  2, 0,0,0,0, R,R, 0,0, 2'b00);
    addSeg(0,  1, 0,0,0,0, R,G, 0,0, 2'b00);

    // Both buttons in the same cycle share one walk.
    s035 = table_q.size();
    addSeg(1,  2, 0,0,0,0, R,R, 0,0, 2'b00);
    addSeg(0,  3, 0,0,0,0, G,R, 0,0, 2'b00);
    addSeg(0,  1, 1,1,0,0, G,R, 0,0, 2'b00);
    addSeg(0,  4, 0,0,0,0, G,R, 0,0, 2'b11);
    addSeg(0,  3, 0,0,0,0, Y,R, 0,0, 2'b11);
    addSeg(0,  2, 0,0,0,0, R,R, 0,0, 2'b11);
    addSeg(0,  6, 0,0,0,0, R,R, 1,1, 2'b00);
    addSeg(0,  2, 0,0,0,0, R,R, 0,0, 2'b00);
    addSeg(0,  1, 0,0,0,0, R,G, 0,0, 2'b00);

    // EW and NS buttons during an NS-only walk: EW queued for walk B,
    // NS ignored because it is being served.
    s036 = table_q.size();
    addSeg(1,  2, 0,0,0,0, R,R, 0,0, 2'b00);
    addSeg(0,  3, 0,0,0,0, G,R, 0,0, 2'b00);
    addSeg(0,  1, 1,0,0,0, G,R, 0,0, 2'b00);
    addSeg(0,  4, 0,0,0,0, G,R, 0,0, 2'b01);
    addSeg(0,  3, 0,0,0,0, Y,R, 0,0, 2'b01);
    addSeg(0,  2, 0,0,0,0, R,R, 0,0, 2'b01);
    addSeg(0,  2, 0,0,0,0, R,R, 1,0, 2'b00);
    addSeg(0,  1, 1,1,0,0, R,R, 1,0, 2'b00);
    addSeg(0,  3, 0,0,0,0, R,R, 1,0, 2'b10);
    addSeg(0,  2, 0,0,0,0, R,R, 0,0, 2'b10);
    addSeg(0,  8, 0,0,0,0, R,G, 0,0, 2'b10);
    addSeg(0,  3, 0,0,0,0, R,Y, 0,0, 2'b10);
    addSeg(0,  2, 0,0,0,0, R,R, 0,0, 2'b10);
    addSeg(0,  6, 0,0,0,0, R,R, 0,1, 2'b00);
    addSeg(0,  2, 0,0,0,0, R,R, 0,0, 2'b00);
    addSeg(0,  1, 0,0,0,0, G,R, 0,0, 2'b00);

    // Lead-in to walk cycle 3 for the asynchronous reset sequence.
    s037 = table_q.size();
    addSeg(1,  2, 0,0,0,0, R,R, 0,0, 2'b00);
    addSeg(0,  3, 0,0,0,0, G,R, 0,0, 2'b00);
    addSeg(0,  1, 1,0,0,0, G,R, 0,0, 2'b00);
    addSeg(0,  4, 0,0,0,0, G,R, 0,0, 2'b01);
    addSeg(0,  3, 0,0,0,0, Y,R, 0,0, 2'b01);
    addSeg(0,  2, 0,0,0,0, R,R, 0,0, 2'b01);
    addSeg(0,  3, 0,0,0,0, R,R, 1,0, 2'b00);
    sEnd = table_q.size();

    runTable(s032, s033, 1'b0);
    runTable(s033, s034, 1'b0);
    runTable(s034, s035, 1'b0);
    runTable(s035, s036, 1'b0);
    runTable(s036, s037, 1'b0);
    runTable(s037, sEnd, 1'b0);

    // Reset mid-walk, between clock edges, with buttons held during reset.
    checkOutput("walk3", R, R, 1'b1, 1'b0, 2'b00);
    #2;
    rst = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("rstAsync", R, R, 1'b0, 1'b0, 2'b00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rstButtons", R, R, 1'b0, 1'b0, 2'b00);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    runTable(s032, s033, 1'b1);

    // Randomized traffic against the reference model.
    doReset();
    begin
      logic carNs = 1'b0;
      logic carEw = 1'b0;
      for (int c = 0; c < 4000; c++) begin
        checkOutput($sformatf("rand%0d", c), lightOf(mPhase, 0), lightOf(mPhase, 5),
                    (mPhase == 3 || mPhase == 8) ? mMask[0] : 1'b0,
                    (mPhase == 3 || mPhase == 8) ? mMask[1] : 1'b0, mPend);
        if ($urandom_range(0, 19) == 0) carNs = ~carNs;
        if ($urandom_range(0, 19) == 0) carEw = ~carEw;
        applyStimulus($urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0, carNs, carEw);
        rst = ($urandom_range(0, 599) == 0);
        @(posedge clk);
        @(negedge clk);
      end
      rst = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
